// File: rtl/pll_clk_sequencer.sv
// pll_clk_sequencer
// Runs on the video PLL output clock. It synchronises the asynchronous PLL
// lock flag and holds the core in reset until lock has been stable for
// HOLD_CYCLES. Once released it generates the pixel clock-enable and the
// 8-phase colour-subcarrier phase/enable. Lock losses while running are
// flagged (sticky) and counted (saturating).
//
// Enable outputs: ce_pix and ce_cb are single-cycle strobes, valid for the
// whole clock cycle in which they are high. There is no back-pressure, so
// consumers must act on every strobe they see.
module pll_clk_sequencer #(
  parameter int HOLD_CYCLES = 1024,
  parameter int DIV_PIX     = 4
) (
  input  logic       clk,
  input  logic       reset_na,
  input  logic       pll_locked,
  input  logic       clr_lost,
  output logic       rst_core_n,
  output logic       ready,
  output logic       ce_pix,
  output logic       ce_cb,
  output logic [2:0] cb_phase,
  output logic       lock_lost,
  output logic [7:0] loss_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Last value of hold_cnt before release, and last pixel divider count.
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [3:0]  PIX_LAST  = 4'(DIV_PIX - 1);

  logic [1:0]  sync_q;
  logic        lock_s;
  state_t      state_q;
  state_t      state_d;
  logic [15:0] hold_cnt;
  logic [3:0]  pix_cnt;
  logic        stay_run;
  logic        loss_evt;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clk or negedge reset_na) begin
    if (!reset_na) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lock_s = sync_q[1];

  // Next-state decode: any low lock_s drops back to WAIT_LOCK; HOLD must
  // see HOLD_CYCLES consecutive high samples before RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = HOLD;
      HOLD: begin
        if (!lock_s)                    state_d = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_d = RUN;
      end
      RUN:       if (!lock_s) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // Counters only advance while remaining in RUN, so each RUN entry starts
  // at phase 0 and the loss cycle already shows phase 0.
  assign stay_run = (state_q == RUN) && (state_d == RUN);
  assign loss_evt = (state_q == RUN) && !lock_s;

  // Sequencer state, registered reset/ready, divider and loss bookkeeping.
  always_ff @(posedge clk or negedge reset_na) begin
    if (!reset_na) begin
      state_q    <= WAIT_LOCK;
      hold_cnt   <= 16'd0;
      rst_core_n <= 1'b0;
      ready      <= 1'b0;
      pix_cnt    <= 4'd0;
      cb_phase   <= 3'd0;
      lock_lost  <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      state_q <= state_d;

      if ((state_q == HOLD) && (state_d == HOLD)) hold_cnt <= hold_cnt + 16'd1;
      else                                        hold_cnt <= 16'd0;

      rst_core_n <= (state_d == RUN);
      ready      <= (state_d == RUN);

      if (stay_run) begin
        pix_cnt  <= (pix_cnt == PIX_LAST) ? 4'd0 : pix_cnt + 4'd1;
        cb_phase <= cb_phase + 3'd1;
      end else begin
        pix_cnt  <= 4'd0;
        cb_phase <= 3'd0;
      end

      // A clear coincident with a loss event is applied first, so the
      // event is then counted from zero.
      if (loss_evt) begin
        lock_lost <= 1'b1;
        if (clr_lost)                 loss_count <= 8'd1;
        else if (loss_count != 8'hff) loss_count <= loss_count + 8'd1;
      end else if (clr_lost) begin
        lock_lost  <= 1'b0;
        loss_count <= 8'd0;
      end
    end
  end

  assign ce_pix    = (state_q == RUN) && (pix_cnt == PIX_LAST);
  assign ce_cb     = (state_q == RUN) && (cb_phase == 3'd7);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Bench for pll_clk_sequencer: a default instance (HOLD 1024, DIV 4) and a
// short instance (HOLD 4, DIV 1). Release instants are pushed into expected
// queues when lock stimulus is applied; monitors pop them on each ready rise.
module tb_pll_clk_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic rst0_n, lk0, clr0;
  logic rst1_n, lk1, clr1;

  logic       rc0, rdy0, cep0, cecb0, lost0;
  logic [2:0] ph0;
  logic [7:0] cnt0;
  logic [1:0] sd0;
  logic       rc1, rdy1, cep1, cecb1, lost1;
  logic [2:0] ph1;
  logic [7:0] cnt1;
  logic [1:0] sd1;

  pll_clk_sequencer #(.HOLD_CYCLES(1024), .DIV_PIX(4)) dut0 (
    .clk(clk), .reset_na(rst0_n), .pll_locked(lk0), .clr_lost(clr0),
    .rst_core_n(rc0), .ready(rdy0), .ce_pix(cep0), .ce_cb(cecb0),
    .cb_phase(ph0), .lock_lost(lost0), .loss_count(cnt0), .state_dbg(sd0)
  );

  pll_clk_sequencer #(.HOLD_CYCLES(4), .DIV_PIX(1)) dut1 (
    .clk(clk), .reset_na(rst1_n), .pll_locked(lk1), .clr_lost(clr1),
    .rst_core_n(rc1), .ready(rdy1), .ce_pix(cep1), .ce_cb(cecb1),
    .cb_phase(ph1), .lock_lost(lost1), .loss_count(cnt1), .state_dbg(sd1)
  );

  // {rst_core_n, ready, ce_pix, ce_cb, cb_phase, lock_lost, loss_count}
  logic [15:0] st0, st1;
  assign st0 = {rc0, rdy0, cep0, cecb0, ph0, lost0, cnt0};
  assign st1 = {rc1, rdy1, cep1, cecb1, ph1, lost1, cnt1};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] e0, e1;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every rising ready must match the next expected release cycle.
  always @(negedge clk) begin
    if (rdy0 && !prev0) begin
      n_tests++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL release0: unexpected rise at cycle %0d", cyc);
      end else begin
        e0 = exp0_q.pop_front();
        if (cyc !== e0) begin
          n_fail++;
          $display("FAIL release0: rose at cycle %0d expected %0d", cyc, e0);
        end
      end
    end
    prev0 = rdy0;
    if (rdy1 && !prev1) begin
      n_tests++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL release1: unexpected rise at cycle %0d", cyc);
      end else begin
        e1 = exp1_q.pop_front();
        if (cyc !== e1) begin
          n_fail++;
          $display("FAIL release1: rose at cycle %0d expected %0d", cyc, e1);
        end
      end
    end
    prev1 = rdy1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready0(input int budget);
    int n = 0;
    while (!rdy0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait0: ready not seen got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic wait_ready1(input int budget);
    int n = 0;
    while (!rdy1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rdy1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait1: ready not seen got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  // Called on the first negedge after release: i counts cycles since edge E.
  task automatic check_run0(input int n, input logic lost, input logic [7:0] cnt);
    logic [2:0]  ph;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      ph  = 3'(i % 8);
      exp = {1'b1, 1'b1, (i % 4) == 3, (i % 8) == 7, ph, lost, cnt};
      check("run0", 32'(st0), 32'(exp));
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] base;
  logic [7:0]  exp_cnt;

  initial begin
    rst0_n = 1'b0; lk0 = 1'b0; clr0 = 1'b0;
    rst1_n = 1'b0; lk1 = 1'b0; clr1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset0", 32'({st0, sd0}), 32'd0);
    check("reset1", 32'({st1, sd1}), 32'd0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle0", 32'({st0, sd0}), 32'd0);

    // Default acquire: release 1027 edges after lock rises.
    lk0 = 1'b1;
    base = cyc;
    exp0_q.push_back(base + 32'd1027);
    repeat (3) @(negedge clk);
    check("hold_entry0", 32'(sd0), 32'd1);
    wait_ready0(1100);
    check_run0(16, 1'b0, 8'd0);

    // Loss in RUN: outputs drop on edge 3 after the fall.
    lk0 = 1'b0;
    base = cyc;
    repeat (2) @(negedge clk);
    check("loss_pre0", 32'({rc0, rdy0, lost0}), 32'b110);
    @(negedge clk);
    check("loss0", 32'(st0), 32'({4'b0000, 3'd0, 1'b1, 8'd1}));
    check("loss_state0", 32'(sd0), 32'd0);

    // Relock, then a one-cycle glitch at HOLD cycle 500 restarts the wait.
    lk0 = 1'b1;
    base = cyc;
    repeat (503) @(negedge clk);
    check("hold500", 32'({sd0, rdy0}), 32'b010);
    lk0 = 1'b0;
    @(negedge clk);
    lk0 = 1'b1;
    base = cyc;
    exp0_q.push_back(base + 32'd1027);
    wait_ready0(1200);
    check_run0(16, 1'b1, 8'd1);

    // Asynchronous reset mid-RUN clears everything, including the loss.
    @(posedge clk);
    #2 rst0_n = 1'b0;
    #1 check("async_rst0", 32'({st0, sd0}), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    base = cyc;
    exp0_q.push_back(base + 32'd1027);
    wait_ready0(1100);
    check_run0(8, 1'b0, 8'd0);

    // DIV_PIX=1 / HOLD=4 instance: ce_pix follows RUN exactly.
    lk1 = 1'b1;
    base = cyc;
    exp1_q.push_back(base + 32'd7);
    for (int k = 0; k < 12; k++) begin
      check("div1", 32'({rdy1, cep1}), (k >= 7) ? 32'b11 : 32'b00);
      @(negedge clk);
    end

    // 300 loss/relock cycles: count saturates at 255.
    exp_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      lk1 = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      check("sat1", 32'({lost1, cnt1, rdy1, cep1}), 32'({1'b1, exp_cnt, 2'b00}));
      lk1 = 1'b1;
      base = cyc;
      exp1_q.push_back(base + 32'd7);
      wait_ready1(20);
    end
    check("sat_final1", 32'(cnt1), 32'd255);

    // Clear coincident with a loss: clear first, then count the event.
    lk1 = 1'b0;
    repeat (2) @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    check("clr_coinc1", 32'({lost1, cnt1}), 32'({1'b1, 8'd1}));
    lk1 = 1'b1;
    base = cyc;
    exp1_q.push_back(base + 32'd7);
    wait_ready1(20);

    // Plain clear while running.
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    check("clr1", 32'({lost1, cnt1}), 32'd0);
    @(negedge clk);
    check("clr_hold1", 32'({lost1, cnt1, rdy1}), 32'b1);

    n_tests++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d/%0d pending releases expected 0/0", exp0_q.size(), exp1_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: time limit reached, stimulus incomplete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
